m_or_carry_reinject_ctrl: RTL and testbench

//  Window controller for a cascaded-OR stochastic adder with carry outputs.
//  - A cascaded OR loses ones whenever two or more input streams are high in the same cycle.
//  - The adder flags these collisions on CARRY0 (>=2 high) and CARRY1 (>=3 high).
//  - This block counts the lost ones over a LEN-cycle stream window.
//  - It re-injects them into idle (zero) slots of the OR output stream.
//  - It sequences the window (start/busy/done) and reports the residual count and saturation.
//  - It sits between the OR-adder and the downstream neuron/activation stage.

---
 rtl/m_or_carry_reinject_ctrl.sv | 101 ++++++++++
 tb/tb_m_or_carry_reinject_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_or_carry_reinject_ctrl.sv
// Window controller for a cascaded-OR stochastic adder: counts ones lost to OR collisions
// and re-injects them into idle output slots. Re-injection is enabled by `OR_CARRY_REINJECT_EN.
module m_or_carry_reinject_ctrl #(
  parameter int LEN = 256,
  parameter int LW  = 16,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          en,
  input  logic          or_in,
  input  logic          carry0,
  input  logic          carry1,
  output logic          out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pend,
  output logic          ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CW-1:0] PEND_MAX = '1;
  localparam logic [LW-1:0] CNT_LAST = LW'(LEN - 1);

  state_t        state, state_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] pend_nxt;
  logic          ovf_nxt;
  logic          out_nxt;
  logic [1:0]    lost;
  logic          drain;
  logic [CW:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= '0;
      ovf   <= 1'b0;
      out   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      ovf   <= ovf_nxt;
      out   <= out_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    ovf_nxt   = ovf;
    out_nxt   = 1'b0;
    lost      = {1'b0, carry0} + {1'b0, carry1};
`ifdef OR_CARRY_REINJECT_EN
    drain     = ~or_in & (pend != '0);
`else
    drain     = 1'b0;
`endif
    // One extra bit so a full counter plus two lost ones is still visible as overflow.
    sum       = {1'b0, pend} + (CW+1)'(lost) - (CW+1)'(drain);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          pend_nxt  = '0;
          ovf_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        if (en) begin
          cnt_nxt = cnt + LW'(1);
          if (sum > {1'b0, PEND_MAX}) begin
            pend_nxt = PEND_MAX;
            ovf_nxt  = 1'b1;
          end else begin
            pend_nxt = sum[CW-1:0];
          end
`ifdef OR_CARRY_REINJECT_EN
          out_nxt = or_in | (pend != '0);
`else
          out_nxt = or_in;
`endif
          if (cnt == CNT_LAST) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_m_or_carry_reinject_ctrl.sv
// Self-checking bench for m_or_carry_reinject_ctrl: a behavioural model feeds a scoreboard,
// plus fixed expectations for the documented scenarios. Follows `OR_CARRY_REINJECT_EN.
module tb_m_or_carry_reinject_ctrl;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, start_sat = 1'b0, en = 1'b0, or_in = 1'b0, carry0 = 1'b0, carry1 = 1'b0;
  logic out, busy, done, ovf;
  logic [7:0] pend;
  logic out_s, busy_s, done_s, ovf_s;
  logic [3:0] pend_s;

  always #5 clk = ~clk;

  m_or_carry_reinject_ctrl #(.LEN(8), .LW(16), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .or_in(or_in),
    .carry0(carry0), .carry1(carry1), .out(out), .busy(busy), .done(done),
    .pend(pend), .ovf(ovf)
  );

  m_or_carry_reinject_ctrl #(.LEN(16), .LW(16), .CW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat), .en(en), .or_in(or_in),
    .carry0(carry0), .carry1(carry1), .out(out_s), .busy(busy_s), .done(done_s),
    .pend(pend_s), .ovf(ovf_s)
  );

`ifdef OR_CARRY_REINJECT_EN
  localparam bit REINJ = 1'b1;
`else
  localparam bit REINJ = 1'b0;
`endif

  typedef struct packed {logic o; logic b; logic d; logic [7:0] p; logic v;} obs_t;
  typedef struct {int st; int cnt; int pend; int ovf;} mdl_t;

  mdl_t m_main, m_sat;
  obs_t q_main[$], q_sat[$];
  int   n_cmp = 0, n_fail = 0;

  // Behavioural model of one clock edge; st: 0 idle, 1 run, 2 done
  task automatic model_tick(inout mdl_t m, input int len, input int cw, input bit s, output obs_t r);
    int pmax = (1 << cw) - 1;
    int l, d;
    bit o_n = 1'b0;
    case (m.st)
      0: if (s) begin m.st = 1; m.cnt = 0; m.pend = 0; m.ovf = 0; end
      1: if (en) begin
        l = int'(carry0) + int'(carry1);
        d = (REINJ && !or_in && m.pend != 0) ? 1 : 0;
        o_n = REINJ ? (or_in || m.pend != 0) : or_in;
        m.pend = m.pend + l - d;
        if (m.pend > pmax) begin m.pend = pmax; m.ovf = 1; end
        if (m.cnt == len - 1) m.st = 2;
        m.cnt++;
      end
      default: m.st = 0;
    endcase
    r.o = o_n; r.b = (m.st == 1); r.d = (m.st == 2); r.p = 8'(m.pend); r.v = (m.ovf != 0);
  endtask

  task automatic model_reset();
    m_main = '{0, 0, 0, 0};
    m_sat  = '{0, 0, 0, 0};
    q_main.delete();
    q_sat.delete();
  endtask

  task automatic step(input bit s, input bit ss, input bit e, input bit o, input bit c0, input bit c1);
    obs_t r;
    start = s; start_sat = ss; en = e; or_in = o; carry0 = c0; carry1 = c1;
    model_tick(m_main, 8, 8, s, r);
    q_main.push_back(r);
    model_tick(m_sat, 16, 4, ss, r);
    q_sat.push_back(r);
    @(posedge clk); #1;
    start = 1'b0; start_sat = 1'b0;
  endtask

  function automatic obs_t obs_main();
    return {out, busy, done, pend, ovf};
  endfunction

  function automatic obs_t obs_sat();
    return {out_s, busy_s, done_s, 4'b0000, pend_s, ovf_s};
  endfunction

  task automatic test_reset();
    obs_t got, exp;
    model_reset();
    @(posedge clk); #1;
    got = obs_main(); n_cmp++;
    if (got !== obs_t'(0)) begin n_fail++; $display("[TB] FAIL reset_init: got %b want 0", got); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 1, 0, 0, 0);
    exp = q_main.pop_front(); got = obs_main(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("[TB] FAIL reset_start: got %b want %b", got, exp); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 1, 1);
      exp = q_main.pop_front(); got = obs_main(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL reset_run %0d: got %b want %b", i, got, exp); end
    end
    #2 rst_n = 1'b0;
    #1 got = obs_main(); n_cmp++;
    if (got !== obs_t'(0)) begin n_fail++; $display("[TB] FAIL reset_async: got %b want 0", got); end
    model_reset();
    en = 1'b0; or_in = 1'b0; carry0 = 1'b0; carry1 = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reinject();
    obs_t got, exp;
    int ep_def[8] = '{2, 4, 6, 5, 4, 3, 2, 1};
    int ep_und[8] = '{2, 4, 6, 6, 6, 6, 6, 6};
    int want_p;
    bit want_o;
    step(1, 0, 1, 0, 0, 0);
    exp = q_main.pop_front(); got = obs_main(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("[TB] FAIL reinject_start: got %b want %b", got, exp); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, i < 3, i < 3, i < 3);
      exp = q_main.pop_front(); got = obs_main(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL reinject_model %0d: got %b want %b", i, got, exp); end
      want_p = REINJ ? ep_def[i] : ep_und[i];
      want_o = REINJ ? 1'b1 : (i < 3);
      n_cmp++;
      if (pend !== 8'(want_p) || out !== want_o || done !== (i == 7)) begin
        n_fail++;
        $display("[TB] FAIL reinject_fixed %0d: pend=%0d out=%b done=%b want pend=%0d out=%b done=%b",
                 i, pend, out, done, want_p, want_o, (i == 7));
      end
    end
    step(0, 0, 0, 0, 0, 0);
    exp = q_main.pop_front(); got = obs_main(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("[TB] FAIL reinject_idle: got %b want %b", got, exp); end
    want_p = REINJ ? 1 : 6;
    n_cmp++;
    if (pend !== 8'(want_p) || ovf !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reinject_final: pend=%0d ovf=%b done=%b want pend=%0d ovf=0 done=0", pend, ovf, done, want_p);
    end
  endtask

  task automatic test_saturation();
    obs_t got, exp;
    int want_p;
    q_sat.delete();
    step(0, 1, 1, 0, 0, 0);
    exp = q_sat.pop_front(); got = obs_sat(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("[TB] FAIL sat_start: got %b want %b", got, exp); end
    for (int i = 0; i < 16; i++) begin
      if (i < 10) step(0, 0, 1, 1, 1, 1);
      else        step(0, 0, 1, 0, 0, 0);
      exp = q_sat.pop_front(); got = obs_sat(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL sat_model %0d: got %b want %b", i, got, exp); end
      if (i < 10) begin
        want_p = (2 * (i + 1) > 15) ? 15 : 2 * (i + 1);
        n_cmp++;
        if (pend_s !== 4'(want_p) || ovf_s !== (i >= 7)) begin
          n_fail++;
          $display("[TB] FAIL sat_fixed %0d: pend=%0d ovf=%b want pend=%0d ovf=%b", i, pend_s, ovf_s, want_p, (i >= 7));
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0);
      exp = q_sat.pop_front(); got = obs_sat(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL sat_hold %0d: got %b want %b", i, got, exp); end
    end
    n_cmp++;
    if (ovf_s !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_ovf_sticky: ovf=%b want 1", ovf_s); end
    step(0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (ovf_s !== 1'b0 || pend_s !== 4'd0 || busy_s !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sat_restart: ovf=%b pend=%0d busy=%b want 0 0 1", ovf_s, pend_s, busy_s);
    end
    void'(q_sat.pop_front());
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 1, 0, 0, 0);
      exp = q_sat.pop_front(); got = obs_sat(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL sat_drain %0d: got %b want %b", i, got, exp); end
    end
    q_main.delete();
  endtask

  task automatic test_pause();
    obs_t got, exp;
    int done_at = -1;
    bit e;
    step(1, 0, 1, 0, 0, 0);
    exp = q_main.pop_front(); got = obs_main(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("[TB] FAIL pause_start: got %b want %b", got, exp); end
    for (int i = 0; i < 13; i++) begin
      e = !(i >= 3 && i < 8);
      step(0, 0, e, i < 3, i < 3, 1'b0);
      exp = q_main.pop_front(); got = obs_main(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL pause_model %0d: got %b want %b", i, got, exp); end
      if (!e) begin
        n_cmp++;
        if (out !== 1'b0 || pend !== 8'd3 || busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL pause_frozen %0d: out=%b pend=%0d busy=%b want 0 3 1", i, out, pend, busy);
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = i;
    end
    n_cmp++;
    if (done_at != 12) begin n_fail++; $display("[TB] FAIL pause_done_time: at %0d want 12", done_at); end
    step(0, 0, 0, 0, 0, 0);
    void'(q_main.pop_front());
  endtask

  task automatic test_control();
    obs_t got, exp;
    step(1, 0, 1, 0, 0, 0);
    void'(q_main.pop_front());
    for (int i = 0; i < 8; i++) begin
      step(i == 3, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp = q_main.pop_front(); got = obs_main(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL ctrl_model %0d: got %b want %b", i, got, exp); end
    end
    n_cmp++;
    if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL ctrl_len: done=%b want 1 after 8 cycles", done); end
    step(0, 0, 0, 0, 0, 0);
    void'(q_main.pop_front());
    step(1, 0, 1, 0, 0, 0);
    void'(q_main.pop_front());
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 1, 0);
      void'(q_main.pop_front());
    end
    #2 rst_n = 1'b0;
    #1 got = obs_main(); n_cmp++;
    if (got !== obs_t'(0)) begin n_fail++; $display("[TB] FAIL ctrl_abort: got %b want 0", got); end
    model_reset();
    en = 1'b0; or_in = 1'b0; carry0 = 1'b0; carry1 = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1, 1, 1);
      exp = q_main.pop_front(); got = obs_main(); n_cmp++;
      if (got !== exp || done !== 1'b0) begin n_fail++; $display("[TB] FAIL ctrl_nodone %0d: got %b want %b", i, got, exp); end
    end
    step(1, 0, 1, 0, 0, 0);
    void'(q_main.pop_front());
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp = q_main.pop_front(); got = obs_main(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("[TB] FAIL ctrl_clean %0d: got %b want %b", i, got, exp); end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_reinject();
    test_saturation();
    test_pause();
    test_control();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
